// File: rtl/event_indicator_if.sv
// Event/indicator bundle between the lock core and the board LED/buzzer pins.
// The master side raises event pulses and the slave side drives indicator levels.
interface event_indicator_if;
  logic ok_pulse;
  logic err_pulse;
  logic led_ok;
  logic led_err;
  logic buzzer;
  logic busy;

  modport master (output ok_pulse, output err_pulse,
                  input  led_ok, input led_err, input buzzer, input busy);
  modport slave  (input  ok_pulse, input err_pulse,
                  output led_ok, output led_err, output buzzer, output busy);
endinterface

// File: rtl/event_indicator.sv
// Stretches single-cycle accept/reject events into timed LED and buzzer levels.
// Accept gives one long beep; reject gives a beep train with the error LED held.
module event_indicator #(
  parameter int ON_CYCLES  = 8,
  parameter int OFF_CYCLES = 4,
  parameter int ERR_BEEPS  = 3,
  parameter int CW         = 8
) (
  input  logic              clk,
  input  logic              rst,
  event_indicator_if.slave  io
);
  typedef enum logic [1:0] {IDLE, OK_ON, ERR_ON, ERR_OFF} state_t;

  localparam logic [CW-1:0] ON_LD   = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LD  = CW'(OFF_CYCLES - 1);
  localparam logic [CW-1:0] NB_LAST = CW'(ERR_BEEPS - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [CW-1:0] nb, nb_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      nb    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      nb    <= nb_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = (cnt == '0) ? '0 : cnt - 1'b1;
    nb_nx    = nb;
    case (state)
      IDLE: begin
        // err wins when both events land in the same cycle
        if (io.err_pulse) begin
          state_nx = ERR_ON;
          cnt_nx   = ON_LD;
          nb_nx    = '0;
        end else if (io.ok_pulse) begin
          state_nx = OK_ON;
          cnt_nx   = ON_LD;
        end
      end
      OK_ON: begin
        if (io.err_pulse) begin
          state_nx = ERR_ON;
          cnt_nx   = ON_LD;
          nb_nx    = '0;
        end else if (cnt == '0) begin
          state_nx = IDLE;
        end
      end
      ERR_ON: begin
        if (cnt == '0) begin
          if (nb == NB_LAST) begin
            state_nx = IDLE;
          end else begin
            state_nx = ERR_OFF;
            cnt_nx   = OFF_LD;
            nb_nx    = nb + 1'b1;
          end
        end
      end
      ERR_OFF: begin
        if (cnt == '0) begin
          state_nx = ERR_ON;
          cnt_nx   = ON_LD;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
        nb_nx    = '0;
      end
    endcase
  end

  // Moore decode: outputs depend on the registered state only
  always_comb begin
    io.led_ok  = 1'b0;
    io.led_err = 1'b0;
    io.buzzer  = 1'b0;
    io.busy    = 1'b0;
    case (state)
      OK_ON: begin
        io.led_ok = 1'b1;
        io.buzzer = 1'b1;
        io.busy   = 1'b1;
      end
      ERR_ON: begin
        io.led_err = 1'b1;
        io.buzzer  = 1'b1;
        io.busy    = 1'b1;
      end
      ERR_OFF: begin
        io.led_err = 1'b1;
        io.busy    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_event_indicator.sv
// Directed bench for event_indicator: accept, reject, preemption, back-to-back,
// async reset and a single-beep variant, against hand-derived cycle windows.
module tb_event_indicator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  event_indicator_if bus ();
  event_indicator_if bus1 ();

  assign bus1.ok_pulse  = bus.ok_pulse;
  assign bus1.err_pulse = bus.err_pulse;

  event_indicator #(.ON_CYCLES(8), .OFF_CYCLES(4), .ERR_BEEPS(3), .CW(8)) dut (
    .clk(clk), .rst(rst), .io(bus.slave));
  event_indicator #(.ON_CYCLES(8), .OFF_CYCLES(4), .ERR_BEEPS(1), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .io(bus1.slave));

  always #5 clk = ~clk;

  // {led_ok, led_err, buzzer, busy}
  localparam logic [3:0] Z  = 4'b0000;
  localparam logic [3:0] OK = 4'b1011;
  localparam logic [3:0] EN = 4'b0111;
  localparam logic [3:0] EF = 4'b0101;

  function automatic logic [3:0] outs();
    return {bus.led_ok, bus.led_err, bus.buzzer, bus.busy};
  endfunction

  function automatic logic [3:0] outs1();
    return {bus1.led_ok, bus1.led_err, bus1.buzzer, bus1.busy};
  endfunction

  // error sequence whose first busy cycle is s: beeps s..s+7, s+12..s+19, s+24..s+31
  function automatic logic [3:0] err_exp(int c, int s);
    int off;
    if (c < s || c > s + 31) return Z;
    off = c - s;
    if ((off >= 8 && off <= 11) || (off >= 20 && off <= 23)) return EF;
    return EN;
  endfunction

  task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    bus.ok_pulse  = 1'b0;
    bus.err_pulse = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_hold", outs(), Z);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // accept: led_ok/buzzer/busy in cycles 11-18
    do_reset();
    for (int c = 1; c <= 25; c++) begin
      tick();
      chk("ok_single", outs(), (cyc >= 11 && cyc <= 18) ? OK : Z);
      bus.ok_pulse = (cyc == 10);
    end

    // reject: 3 beeps in 11-42; single-beep instance covers 11-18 only
    do_reset();
    for (int c = 1; c <= 48; c++) begin
      tick();
      chk("err_single", outs(), err_exp(cyc, 11));
      chk("err_one_beep", outs1(), (cyc >= 11 && cyc <= 18) ? EN : Z);
      bus.err_pulse = (cyc == 10);
    end

    // both together: err wins, led_ok never asserts
    do_reset();
    for (int c = 1; c <= 48; c++) begin
      tick();
      chk("both", outs(), err_exp(cyc, 11));
      bus.ok_pulse  = (cyc == 10);
      bus.err_pulse = (cyc == 10);
    end

    // err preempts ok: led_ok 11-13, error sequence 14-45
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      tick();
      chk("preempt", outs(), (cyc >= 11 && cyc <= 13) ? OK : err_exp(cyc, 14));
      bus.ok_pulse  = (cyc == 10);
      bus.err_pulse = (cyc == 13);
    end

    // pulses ignored mid-sequence; ok on first idle cycle 43 -> led_ok 44-51
    do_reset();
    for (int c = 1; c <= 56; c++) begin
      tick();
      chk("ignore_b2b", outs(), (cyc >= 44 && cyc <= 51) ? OK : err_exp(cyc, 11));
      bus.err_pulse = (cyc == 10 || cyc == 25);
      bus.ok_pulse  = (cyc == 15 || cyc == 43);
    end

    // async reset in cycle 20 of an error sequence
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk("pre_async", outs(), err_exp(cyc, 11));
      bus.err_pulse = (cyc == 10);
    end
    #3;
    rst = 1'b1;
    #1;
    chk("async_drop", outs(), Z);
    tick();
    chk("async_held", outs(), Z);
    #3;
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("post_rst_idle", outs(), Z);
    end
    bus.ok_pulse = 1'b1;
    tick();
    bus.ok_pulse = 1'b0;
    chk("post_rst_ok", outs(), OK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/event_indicator.md
Name: event_indicator

Overview:
- Output-side counterpart to the button pulse conditioner in the digital lock.
- Takes single-cycle event pulses from the lock core (code accepted / code rejected) and stretches them into timed, human-visible LED and buzzer levels.
- Accept: one long beep. Reject: a train of beeps with the error LED held through the whole sequence.
- Sits between the lock FSM and the board LED/buzzer pins.

Parameters:
- ON_CYCLES, 8, length in clocks of each buzzer-on phase; must be >= 1.
- OFF_CYCLES, 4, length in clocks of each gap between error beeps; must be >= 1.
- ERR_BEEPS, 3, number of beeps in an error sequence; must be >= 1.
- CW, 8, width of the phase and beep counters; must hold max(ON_CYCLES, OFF_CYCLES, ERR_BEEPS).

Ports:
- Clock  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous reset, active-high.
- ok_pulse  input  1  one-cycle "code accepted" event.
- err_pulse  input  1  one-cycle "code rejected" event.
- led_ok  output  1  accept LED.
- led_err  output  1  error LED.
- buzzer  output  1  buzzer drive.
- busy  output  1  high while any sequence is running.

Behaviour:
- Reset: asynchronous, active-high. Reset=1 forces state IDLE, counters 0, and all outputs 0 immediately (no clock needed). This holds mid-sequence too; there is no resume after reset is released.
- Moore machine: all outputs decode from the registered state only, so there are no combinational paths from inputs to outputs.
- States: IDLE, OK_ON, ERR_ON, ERR_OFF.
- Phase counter (cnt): loaded with the phase length minus 1 on entry to a phase, and decrements each cycle. The phase ends on the cycle where cnt == 0.
- Beep counter (nb): counts completed error beeps.
- Output decode:
  - IDLE: all outputs 0.
  - OK_ON: led_ok=1, buzzer=1, busy=1.
  - ERR_ON: led_err=1, buzzer=1, busy=1.
  - ERR_OFF: led_err=1, buzzer=0, busy=1.
- Latency: a pulse sampled high at edge k makes the outputs change after edge k, i.e. visible in cycle k+1.
- IDLE transitions:
  - err_pulse=1 -> ERR_ON, with cnt=ON_CYCLES-1 and nb=0.
  - Otherwise, ok_pulse=1 -> OK_ON, with cnt=ON_CYCLES-1.
  - Both high in the same cycle: err wins.
- OK_ON transitions:
  - err_pulse=1 preempts: go to ERR_ON, reload cnt=ON_CYCLES-1, nb=0. led_ok drops and led_err rises in the same cycle.
  - Otherwise, when cnt==0 -> IDLE.
  - ok_pulse is ignored (no restart, no extension).
- ERR_ON transitions:
  - When cnt==0: if nb==ERR_BEEPS-1, go to IDLE (no trailing gap).
  - Otherwise go to ERR_OFF, with cnt=OFF_CYCLES-1 and nb=nb+1.
- ERR_OFF transitions: when cnt==0 -> ERR_ON, with cnt=ON_CYCLES-1.
- ok_pulse and err_pulse are both ignored in ERR_ON and ERR_OFF.
- Sequence lengths:
  - OK sequence: busy for exactly ON_CYCLES cycles.
  - Error sequence: busy for exactly ERR_BEEPS*ON_CYCLES + (ERR_BEEPS-1)*OFF_CYCLES cycles.
  - With ERR_BEEPS=1: a single beep, no ERR_OFF visit.
- Inputs held high: inputs are sampled as levels, not edges. A level still high when IDLE is re-entered starts a new sequence the next cycle; the upstream conditioner guarantees single-cycle pulses in normal use.
- Back-to-back: a pulse arriving in the same cycle that IDLE is re-entered is accepted. Minimum one IDLE cycle between sequences (all outputs 0 for that cycle).
- Illegal state encodings recover to IDLE on the next clock.

Test Plan (ON_CYCLES=8, OFF_CYCLES=4, ERR_BEEPS=3):
- Reset then a single ok_pulse at cycle 10 -> led_ok=buzzer=busy=1 for cycles 11-18. All outputs 0 from cycle 19. led_err stays 0 throughout.
- Single err_pulse at cycle 10 -> buzzer high for cycles 11-18, 23-30 and 35-42, low in 19-22 and 31-34. led_err and busy high for cycles 11-42 continuously, all 0 at cycle 43.
- ok_pulse and err_pulse high in the same cycle -> full 32-cycle error sequence; led_ok never asserts.
- ok_pulse at cycle 10, err_pulse at cycle 13 -> led_ok high for cycles 11-13 only. The error sequence starts at cycle 14, its first buzzer phase covers cycles 14-21, and busy stays high until cycle 45.
- Extra ok_pulse and err_pulse during an error sequence (cycles 15 and 25) -> timing identical to the single-error case. A new ok_pulse arriving on the first IDLE cycle (cycle 43) -> led_ok high for cycles 44-51.
- Reset asserted asynchronously (between clock edges) at cycle 20 of an error sequence -> buzzer, led_err and busy drop without waiting for a clock. After release, outputs stay 0 until the next pulse.
